// File: rtl/packet_pkg.sv
// Shared packet constants: bus widths, header field positions, reader FSM states, buffer word layout.
// Pure definitions with no timing or backpressure of their own.
package packet_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int HDR_WIDTH  = DATA_WIDTH / 2;
  localparam int DEPTH      = 8;

  localparam int DEST_LSB = 0;
  localparam int DEST_MSB = 1;
  localparam int LEN_LSB  = 2;
  localparam int LEN_MSB  = 7;

  localparam int DEST_W = DEST_MSB - DEST_LSB + 1;
  localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
  localparam int CNT_W  = LEN_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_XFER,
    ST_DRAIN
  } rd_state_t;

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } buf_word_t;

  function automatic logic [3:0] dest_onehot(input logic [DEST_W-1:0] dest);
    return 4'b0001 << dest;
  endfunction

endpackage

// File: rtl/pkt_skid_buf.sv
// 2-entry in-order output buffer: a push lands one cycle before it can be presented, a head word is held while !ready,
// and the writer must not push into a full buffer (a simultaneous push and pop leaves the count unchanged).
module pkt_skid_buf #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] rd_data,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic         pop;

  assign valid   = (count != 2'd0);
  assign pop     = valid && ready;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= !wr_ptr;
      end
      if (pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/pkt_reader.sv
// Drains one input FIFO: peeks the header, requests output DEST, streams LEN+1 words with sop/eop, one word/cycle from 2 cycles after grant.
// out_ready backpressure throttles FIFO pops through a 2-entry skid buffer; PKT_READER_LOOPBACK_DROP_EN silently drops packets addressed to PORT_ID.
module pkt_reader
  import packet_pkg::*;
#(
  parameter int PORT_ID = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [HDR_WIDTH-1:0]  fifo_header,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic [3:0]            req,
  input  logic                  grant,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            out_dest
);

`ifdef PKT_READER_LOOPBACK_DROP_EN
  localparam bit LOOPBACK_DROP = 1'b1;
`else
  localparam bit LOOPBACK_DROP = 1'b0;
`endif

  localparam int BUF_W = $bits(buf_word_t);

  rd_state_t         state;
  rd_state_t         state_nxt;
  logic [DEST_W-1:0] dest_q;
  logic [DEST_W-1:0] hdr_dest;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  hdr_len;
  logic [LEN_W-1:0]  cnt_len;
  logic              drop_q;
  logic              is_loop;
  logic              load_hdr;
  logic              load_cnt;
  logic [CNT_W-1:0]  rd_remaining;
  logic [CNT_W-1:0]  wr_idx;
  logic              inflight;
  logic              pop;
  logic              push;
  logic              room;
  logic [1:0]        buf_count;
  logic              buf_valid;
  buf_word_t         wr_word;
  buf_word_t         rd_word;

  assign hdr_dest = fifo_header[DEST_MSB:DEST_LSB];
  assign hdr_len  = fifo_header[LEN_MSB:LEN_LSB];
  assign is_loop  = LOOPBACK_DROP && (hdr_dest == PORT_ID[DEST_W-1:0]);

  assign pop  = buf_valid && out_ready;
  assign push = inflight && !drop_q;

  // Occupancy after this edge must stay within the 2 buffer slots, counting the word still on its way from the FIFO.
  assign room = (({1'b0, buf_count} + {2'b00, inflight}) - {2'b00, pop}) < 3'd2;

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    req        = 4'b0000;
    load_hdr   = 1'b0;
    load_cnt   = 1'b0;
    cnt_len    = len_q;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          load_hdr = 1'b1;
          if (is_loop) begin
            load_cnt  = 1'b1;
            cnt_len   = hdr_len;
            state_nxt = ST_XFER;
          end else begin
            state_nxt = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        req = dest_onehot(dest_q);
        if (grant) begin
          load_cnt  = 1'b1;
          state_nxt = ST_XFER;
        end
      end
      ST_XFER: begin
        req        = drop_q ? 4'b0000 : dest_onehot(dest_q);
        fifo_rd_en = !fifo_empty && (rd_remaining != '0) && room;
        if (fifo_rd_en && (rd_remaining == CNT_W'(1))) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        req = drop_q ? 4'b0000 : dest_onehot(dest_q);
        if ((buf_count == 2'd0) && !inflight) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dest_q       <= '0;
      len_q        <= '0;
      drop_q       <= 1'b0;
      rd_remaining <= '0;
      wr_idx       <= '0;
      inflight     <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (load_hdr) begin
        dest_q <= hdr_dest;
        len_q  <= hdr_len;
        drop_q <= is_loop;
      end
      if (load_cnt) begin
        rd_remaining <= {1'b0, cnt_len} + CNT_W'(1);
        wr_idx       <= '0;
      end else begin
        if (fifo_rd_en) begin
          rd_remaining <= rd_remaining - CNT_W'(1);
        end
        if (push) begin
          wr_idx <= wr_idx + CNT_W'(1);
        end
      end
    end
  end

  // Word position is tagged on entry so sop/eop travel with the data through the buffer.
  assign wr_word.sop  = (wr_idx == '0);
  assign wr_word.eop  = (wr_idx == {1'b0, len_q});
  assign wr_word.data = fifo_data;

  pkt_skid_buf #(
    .W(BUF_W)
  ) u_skid_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (wr_word),
    .ready   (out_ready),
    .valid   (buf_valid),
    .rd_data (rd_word),
    .count   (buf_count)
  );

  assign out_valid = buf_valid;
  assign out_sop   = buf_valid && rd_word.sop;
  assign out_eop   = buf_valid && rd_word.eop;
  assign out_data  = buf_valid ? rd_word.data : '0;
  assign out_dest  = dest_q;

endmodule

// File: tb/tb_pkt_reader.sv
// Directed bench for pkt_reader: FIFO and arbiter models around the DUT, a negedge monitor, and hand-computed packet expectations.
module tb_pkt_reader;
  import packet_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  fifo_empty;
  logic [HDR_WIDTH-1:0]  fifo_header;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic [3:0]            req;
  logic                  grant = 1'b0;
  logic                  out_ready;
  logic                  out_valid;
  logic                  out_sop;
  logic                  out_eop;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_dest;

  pkt_reader #(.PORT_ID(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_empty  (fifo_empty),
    .fifo_header (fifo_header),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_data   (fifo_data),
    .req         (req),
    .grant       (grant),
    .out_ready   (out_ready),
    .out_valid   (out_valid),
    .out_sop     (out_sop),
    .out_eop     (out_eop),
    .out_data    (out_data),
    .out_dest    (out_dest)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: registered read data, header peek of the head word
  logic [DATA_WIDTH-1:0] fq[$];

  task automatic refresh();
    fifo_empty  = (fq.size() == 0);
    fifo_header = (fq.size() > 0) ? fq[0][HDR_WIDTH-1:0] : '0;
  endtask

  task automatic send(input logic [DATA_WIDTH-1:0] w[$], input int lo, input int hi);
    for (int i = lo; i < hi; i++) fq.push_back(w[i]);
    refresh();
  endtask

  always begin
    @(posedge clk);
    if (rst_n && fifo_rd_en && (fq.size() > 0)) fifo_data <= fq.pop_front();
    #1 refresh();
  end

  // Arbiter model: grant follows req one cycle later and holds until req drops
  logic req_pre;
  always begin
    @(posedge clk);
    req_pre = |req;
    #1 grant = req_pre;
  end

  logic toggle_rdy = 1'b0;
  always begin
    @(posedge clk);
    #1;
    if (toggle_rdy) out_ready = ~out_ready;
  end

  // Monitor
  int                    cyc = 0;
  logic [DATA_WIDTH-1:0] acc_data[$];
  logic                  acc_sop[$];
  logic                  acc_eop[$];
  logic [1:0]            acc_dest[$];
  int                    acc_cyc[$];
  logic [3:0]            req_seen, req_after1, req_after2;
  int                    grant_cyc, eop_cyc, pops, accepted, max_out, valid_cnt, rd_empty_viol, stab_viol;
  logic                  prev_stall;
  logic [DATA_WIDTH-1:0] prev_data;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      pops       = 0;
      accepted   = 0;
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en && fifo_empty) rd_empty_viol++;
      if (fifo_rd_en) pops++;
      if (prev_stall && (!out_valid || (out_data != prev_data))) stab_viol++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (out_valid) valid_cnt++;
      if ((req != 4'b0000) && (req_seen == 4'b0000)) req_seen = req;
      if (grant && (grant_cyc < 0)) grant_cyc = cyc;
      if ((eop_cyc >= 0) && (cyc == eop_cyc + 1)) req_after1 = req;
      if ((eop_cyc >= 0) && (cyc == eop_cyc + 2)) req_after2 = req;
      if (out_valid && out_ready) begin
        accepted++;
        acc_data.push_back(out_data);
        acc_sop.push_back(out_sop);
        acc_eop.push_back(out_eop);
        acc_dest.push_back(out_dest);
        acc_cyc.push_back(cyc);
        if (out_eop) eop_cyc = cyc;
      end
      if (pops - accepted > max_out) max_out = pops - accepted;
    end
  end

  task automatic clear_mon();
    acc_data.delete();
    acc_sop.delete();
    acc_eop.delete();
    acc_dest.delete();
    acc_cyc.delete();
    req_seen      = 4'b0000;
    req_after1    = 4'hF;
    req_after2    = 4'hF;
    grant_cyc     = -1;
    eop_cyc       = -1;
    pops          = 0;
    accepted      = 0;
    max_out       = 0;
    valid_cnt     = 0;
    rd_empty_viol = 0;
    stab_viol     = 0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (acc_data.size() >= n) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_packet(input string name, input logic [DATA_WIDTH-1:0] exp[$],
                              input logic [3:0] exp_req, input logic [1:0] exp_dest);
    check({name, ".nwords"}, acc_data.size(), exp.size());
    foreach (exp[i]) begin
      if (i < acc_data.size()) begin
        check($sformatf("%s.w%0d.data", name, i), 32'(acc_data[i]), 32'(exp[i]));
        check($sformatf("%s.w%0d.sop", name, i), 32'(acc_sop[i]), 32'(i == 0));
        check($sformatf("%s.w%0d.eop", name, i), 32'(acc_eop[i]), 32'(i == exp.size() - 1));
        check($sformatf("%s.w%0d.dest", name, i), 32'(acc_dest[i]), 32'(exp_dest));
      end
    end
    check({name, ".req"}, 32'(req_seen), 32'(exp_req));
    check({name, ".req_hold"}, 32'(req_after1), 32'(exp_req));
    check({name, ".req_drop"}, 32'(req_after2), 32'(0));
    check({name, ".stable"}, stab_viol, 0);
    check({name, ".rd_while_empty"}, rd_empty_viol, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, ".req"}, 32'(req), 32'(0));
    check({name, ".rd_en"}, 32'(fifo_rd_en), 32'(0));
    check({name, ".valid"}, 32'(out_valid), 32'(0));
    check({name, ".sop"}, 32'(out_sop), 32'(0));
    check({name, ".eop"}, 32'(out_eop), 32'(0));
    check({name, ".data"}, 32'(out_data), 32'(0));
    check({name, ".dest"}, 32'(out_dest), 32'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [DATA_WIDTH-1:0] pk[$];
  logic [DATA_WIDTH-1:0] pk2[$];

  initial begin
    rst_n     = 1'b1;
    out_ready = 1'b0;
    fifo_data = '0;
    refresh();
    clear_mon();
    #3 rst_n = 1'b0;
    idle(3);
    check_outputs_zero("reset");

    rst_n     = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // DEST 1, LEN 3, out_ready high
    clear_mon();
    pk = '{16'h000D, 16'h1111, 16'h2222, 16'h3333};
    send(pk, 0, pk.size());
    wait_words(4, 50);
    idle(4);
    check_packet("p034", pk, 4'b0010, 2'd1);
    if (acc_cyc.size() == 4) begin
      check("p034.latency", acc_cyc[0] - (grant_cyc + 1), 2);
      check("p034.span", acc_cyc[3] - acc_cyc[0], 3);
    end

    // Same packet with out_ready toggling every cycle
    clear_mon();
    pk = '{16'h000D, 16'h4444, 16'h5555, 16'h6666};
    toggle_rdy = 1'b1;
    send(pk, 0, pk.size());
    wait_words(4, 80);
    toggle_rdy = 1'b0;
    idle(1);
    out_ready = 1'b1;
    idle(4);
    check_packet("p035", pk, 4'b0010, 2'd1);
    check("p035.outstanding_le2", 32'(max_out <= 2), 32'(1));

    // Reset in the middle of a 4-word packet
    clear_mon();
    pk = '{16'h000D, 16'h7777, 16'h8888, 16'h9999};
    send(pk, 0, pk.size());
    wait_words(2, 50);
    check("p038.busy_before", 32'(out_valid), 32'(1));
    rst_n = 1'b0;
    fq.delete();
    refresh();
    #1;
    check_outputs_zero("p038.in_reset");
    idle(2);
    rst_n = 1'b1;
    clear_mon();
    idle(6);
    check("p038.req_after", 32'(req_seen), 32'(0));
    check("p038.valid_after", valid_cnt, 0);
    check("p038.pops_after", pops, 0);

    // DEST 2, LEN 0: single word, sop and eop together
    clear_mon();
    pk = '{16'h0002};
    send(pk, 0, pk.size());
    wait_words(1, 50);
    idle(4);
    check_packet("p036", pk, 4'b0100, 2'd2);

    // DEST 3, LEN 4 with the FIFO running dry after 2 words
    clear_mon();
    pk = '{16'h0013, 16'hA001, 16'hA002, 16'hA003, 16'hA004};
    send(pk, 0, 2);
    wait_words(2, 50);
    idle(6);
    check("p037.stalled_words", acc_data.size(), 2);
    check("p037.stall_valid", 32'(out_valid), 32'(0));
    send(pk, 2, pk.size());
    wait_words(5, 50);
    idle(4);
    check_packet("p037", pk, 4'b1000, 2'd3);

`ifdef PKT_READER_LOOPBACK_DROP_EN
    // Self-addressed packet is popped and discarded, next packet forwarded
    clear_mon();
    pk = '{16'h0004, 16'hBEEF};
    send(pk, 0, pk.size());
    idle(12);
    check("p039.req", 32'(req_seen), 32'(0));
    check("p039.pops", pops, 2);
    check("p039.valid", valid_cnt, 0);
    clear_mon();
    pk2 = '{16'h0007, 16'hCAFE};
    send(pk2, 0, pk2.size());
    wait_words(2, 50);
    idle(4);
    check_packet("p039.fwd", pk2, 4'b1000, 2'd3);
`else
    // Self-addressed packet forwarded like any other
    clear_mon();
    pk = '{16'h0004, 16'hBEEF};
    send(pk, 0, pk.size());
    wait_words(2, 50);
    idle(4);
    check_packet("p031.self", pk, 4'b0001, 2'd0);
    pk2 = '{16'h0007, 16'hCAFE};
    clear_mon();
    send(pk2, 0, pk2.size());
    wait_words(2, 50);
    idle(4);
    check_packet("p031.next", pk2, 4'b1000, 2'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
